// File: rtl/config_mem_unit.sv
// Configuration store: one commit per write_en episode, registered read port, key slot 7.
// Optional write lock via CFGMEM_LOCK_EN (locked tied low when undefined).
module config_mem_unit (
    input  logic        clk,
    input  logic        arst,
    input  logic        write_en,
    input  logic [34:0] configin,
    input  logic [2:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic [1:0]  syskey,
    output logic        wr_done,
    output logic [7:0]  wr_count,
    output logic        locked
);

    typedef enum logic {ARMED, HELD} state_e;

    state_e      state_q, state_d;
    logic        arm_hit;
    logic        commit;
    logic        write_ok;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;

    logic [31:0] mem_q [8];
    logic [31:0] rd_data_q;
    logic [1:0]  syskey_q;
    logic        wr_done_q;
    logic [7:0]  wr_count_q, wr_count_d;

    assign wr_addr = configin[34:32];
    assign wr_data = configin[31:0];

    always_comb begin
        state_d = state_q;
        arm_hit = 1'b0;
        case (state_q)
            ARMED: begin
                if (write_en) begin
                    state_d = HELD;
                    arm_hit = 1'b1;
                end
            end
            HELD: begin
                if (!write_en) state_d = ARMED;
            end
            default: state_d = ARMED;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) state_q <= ARMED;
        else      state_q <= state_d;
    end

`ifdef CFGMEM_LOCK_EN
    logic locked_q;

    // Slot-7 write with bit 31 set completes, then blocks all later writes.
    always_ff @(posedge clk or posedge arst) begin
        if (arst)
            locked_q <= 1'b0;
        else if (commit && wr_addr == 3'd7 && wr_data[31])
            locked_q <= 1'b1;
    end

    assign write_ok = ~locked_q;
    assign locked   = locked_q;
`else
    assign write_ok = 1'b1;
    assign locked   = 1'b0;
`endif

    assign commit = arm_hit & write_ok;

    always_comb begin
        wr_count_d = wr_count_q;
        if (commit && wr_count_q != 8'hFF)
            wr_count_d = wr_count_q + 8'd1;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < 8; i++) mem_q[i] <= '0;
            rd_data_q  <= '0;
            syskey_q   <= '0;
            wr_done_q  <= 1'b0;
            wr_count_q <= '0;
        end else begin
            // Read samples pre-write contents: same-slot collisions return old data.
            rd_data_q  <= mem_q[rd_addr];
            wr_done_q  <= commit;
            wr_count_q <= wr_count_d;
            if (commit) begin
                mem_q[wr_addr] <= wr_data;
                if (wr_addr == 3'd7) syskey_q <= wr_data[1:0];
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign syskey   = syskey_q;
    assign wr_done  = wr_done_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_config_mem_unit.sv
// Directed bench for config_mem_unit: vector table plus reset, saturation and lock sequences.
module tb_config_mem_unit;

    logic        clk = 1'b0;
    logic        arst;
    logic        write_en;
    logic [34:0] configin;
    logic [2:0]  rd_addr;
    logic [31:0] rd_data;
    logic [1:0]  syskey;
    logic        wr_done;
    logic [7:0]  wr_count;
    logic        locked;

    int errors = 0;
    int checks = 0;

    config_mem_unit dut (
        .clk      (clk),
        .arst     (arst),
        .write_en (write_en),
        .configin (configin),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .syskey   (syskey),
        .wr_done  (wr_done),
        .wr_count (wr_count),
        .locked   (locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [34:0] cfg;
        logic [2:0]  ra;
        logic [31:0] rd;
        logic [1:0]  key;
        logic        done;
        logic [7:0]  cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic we, logic [2:0] wa, logic [31:0] wd,
                                logic [2:0] ra, logic [31:0] rd,
                                logic [1:0] key, logic done, logic [7:0] cnt);
        vec_t v;
        v.we = we; v.cfg = {wa, wd}; v.ra = ra; v.rd = rd;
        v.key = key; v.done = done; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, " rd_data"},  rd_data,        32'h0);
        chk({tag, " syskey"},   {30'h0, syskey}, 32'h0);
        chk({tag, " wr_done"},  {31'h0, wr_done}, 32'h0);
        chk({tag, " wr_count"}, {24'h0, wr_count}, 32'h0);
        chk({tag, " locked"},   {31'h0, locked}, 32'h0);
    endtask

    task automatic do_reset();
        #3 arst = 1'b1;
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        arst = 1'b0;
    endtask

    int exp_cnt;

    initial begin
        arst = 1'b1; write_en = 1'b0; configin = '0; rd_addr = '0;
        #2;
        chk_all_zero("por");
        @(negedge clk);
        arst = 1'b0;

        // held write, HELD ignores configin, key update, collision
        tbl.push_back(mk(1, 3'd2, 32'h1234_5678, 3'd2, 32'h0,         2'b00, 1, 8'd1));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1, 3'd2, 32'h1234_5678, 3'd2, 32'h1234_5678, 2'b00, 0, 8'd1));
        tbl.push_back(mk(1, 3'd2, 32'hFFFF_FFFF, 3'd2, 32'h1234_5678, 2'b00, 0, 8'd1));
        tbl.push_back(mk(0, 3'd2, 32'hFFFF_FFFF, 3'd2, 32'h1234_5678, 2'b00, 0, 8'd1));
        tbl.push_back(mk(1, 3'd7, 32'h0000_0003, 3'd7, 32'h0,         2'b11, 1, 8'd2));
        tbl.push_back(mk(0, 3'd7, 32'h0000_0003, 3'd7, 32'h0000_0003, 2'b11, 0, 8'd2));
        tbl.push_back(mk(1, 3'd3, 32'h0000_000A, 3'd3, 32'h0,         2'b11, 1, 8'd3));
        tbl.push_back(mk(0, 3'd3, 32'h0000_000A, 3'd3, 32'h0000_000A, 2'b11, 0, 8'd3));
        tbl.push_back(mk(1, 3'd2, 32'hDEAD_BEEF, 3'd2, 32'h1234_5678, 2'b11, 1, 8'd4));
        tbl.push_back(mk(0, 3'd2, 32'hDEAD_BEEF, 3'd2, 32'hDEAD_BEEF, 2'b11, 0, 8'd4));
        tbl.push_back(mk(0, 3'd0, 32'h0,         3'd0, 32'h0,         2'b11, 0, 8'd4));

        #4;
        foreach (tbl[i]) begin
            write_en = tbl[i].we;
            configin = tbl[i].cfg;
            rd_addr  = tbl[i].ra;
            step();
            chk($sformatf("vec%0d rd_data", i),  rd_data,           tbl[i].rd);
            chk($sformatf("vec%0d syskey", i),   {30'h0, syskey},   {30'h0, tbl[i].key});
            chk($sformatf("vec%0d wr_done", i),  {31'h0, wr_done},  {31'h0, tbl[i].done});
            chk($sformatf("vec%0d wr_count", i), {24'h0, wr_count}, {24'h0, tbl[i].cnt});
            chk($sformatf("vec%0d locked", i),   {31'h0, locked},   32'h0);
        end

        // saturation: continue from 4 commits
        exp_cnt = 4;
        for (int p = 0; p < 260; p++) begin
            write_en = 1'b1;
            configin = {3'd1, 32'(p)};
            step();
            if (exp_cnt < 255) exp_cnt++;
            chk("sat wr_done hi", {31'h0, wr_done}, 32'h1);
            chk("sat wr_count", {24'h0, wr_count}, exp_cnt);
            write_en = 1'b0;
            step();
            chk("sat wr_done lo", {31'h0, wr_done}, 32'h0);
        end
        chk("sat final", {24'h0, wr_count}, 32'hFF);

        // mid-cycle reset with arbitrary inputs, then every slot reads 0
        write_en = 1'b1; configin = {3'd5, 32'hA5A5_A5A5}; rd_addr = 3'd1;
        do_reset();
        write_en = 1'b0;
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            step();
            chk($sformatf("post-reset slot%0d", a), rd_data, 32'h0);
        end

        // reset while HELD with write_en still high: first edge after release commits
        write_en = 1'b1; configin = {3'd4, 32'h0000_0055}; rd_addr = 3'd4;
        step();
        chk("held pre-reset done", {31'h0, wr_done}, 32'h1);
        step();
        chk("held no repeat", {31'h0, wr_done}, 32'h0);
        do_reset();
        step();
        chk("rearm commit done", {31'h0, wr_done}, 32'h1);
        chk("rearm commit count", {24'h0, wr_count}, 32'h1);
        write_en = 1'b0;
        step();
        chk("rearm data", rd_data, 32'h0000_0055);

`ifdef CFGMEM_LOCK_EN
        do_reset();
        write_en = 1'b1; configin = {3'd7, 32'h8000_0001};
        step();
        chk("lock set", {31'h0, locked}, 32'h1);
        chk("lock key", {30'h0, syskey}, 32'h1);
        chk("lock done", {31'h0, wr_done}, 32'h1);
        write_en = 1'b0;
        step();
        write_en = 1'b1; configin = {3'd0, 32'h1111_2222}; rd_addr = 3'd0;
        step();
        chk("locked no done", {31'h0, wr_done}, 32'h0);
        chk("locked count", {24'h0, wr_count}, 32'h1);
        write_en = 1'b0;
        step();
        step();
        chk("locked slot0", rd_data, 32'h0);
        chk("locked key kept", {30'h0, syskey}, 32'h1);
        #3 arst = 1'b1;
        #1;
        chk("lock cleared", {31'h0, locked}, 32'h0);
        @(negedge clk);
        arst = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
